gs_mem_arb: RTL and testbench

Parametrised multi-port memory front end for the GoldenSnitch core. It accepts word requests from NUM_PORTS masters (instruction fetch, load/store, future DMA) over valid/ready, arbitrates round-robin onto one single-port SRAM_wrapper macro, and returns read data with a fixed, tagged latency. It replaces direct core-to-SRAM wiring in GS_Top, so IM and DM can share one bank or each get their own arbiter instance.

---
 rtl/gs_pkg.sv | 27 ++
 rtl/gs_rr_arbiter.sv | 54 +++++
 rtl/gs_mem_arb.sv | 158 +++++++++++++++
 tb/tb_gs_mem_arb.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// gs_pkg
// Shared types and helpers for the GoldenSnitch memory front end.
//   GS_MEM_READ  : all-zero byte write-enable pattern that marks a read
//   mem_req_t    : one word request {we, addr, wdata} at the core's native
//                  32-bit address / 32-bit data / 4-lane geometry
//   gs_tag_width : bits needed to name one of n ports (at least 1)
package gs_pkg;

    localparam int GS_ADDR_SIZE = 32;
    localparam int GS_WORD_SIZE = 32;
    localparam int GS_BYTES     = GS_WORD_SIZE / 8;

    localparam logic [GS_BYTES-1:0] GS_MEM_READ = '0;

    typedef struct packed {
        logic [GS_BYTES-1:0]     we;
        logic [GS_ADDR_SIZE-1:0] addr;
        logic [GS_WORD_SIZE-1:0] wdata;
    } mem_req_t;

    // A single port still needs a one-bit tag so the tag register never
    // collapses to zero width.
    function automatic int gs_tag_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gs_rr_arbiter.sv
// gs_rr_arbiter
// Round-robin arbiter with a combinational one-hot grant.
//   clk, rst   : clock, synchronous active-low reset
//   req        : NUM_PORTS request vector
//   grant      : one-hot grant, same cycle as the request
//   grant_idx  : binary index of the granted port
//   grant_any  : at least one port granted this cycle
// Every grant is treated as a completed handshake, so the pointer moves to
// the port after the winner whenever grant_any is high.
module gs_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_any
);

    logic [IDX_W-1:0] rr_ptr;

    // Scan ports starting at rr_ptr and wrapping; the first requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_PORTS;
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    // Pointer wraps explicitly because NUM_PORTS need not be a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            if (int'(grant_idx) == NUM_PORTS - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/gs_mem_arb.sv
// gs_mem_arb
// Multi-port word memory front end: round-robin arbitration of NUM_PORTS
// valid/ready masters onto one single-port SRAM macro, with tagged read
// responses.
//   clk, rst                  : clock, synchronous active-low reset
//   req_valid/req_ready       : per-port handshake (ready is same-cycle)
//   req_we/req_addr/req_wdata : per-port flattened request fields
//   rsp_valid                 : per-port one-cycle read-data pulse
//   rsp_rdata                 : shared read data, holds last value
//   sram_cs/oe/web/a/di/do    : SRAM macro interface (web active-low)
// Build option: define GS_MEM_ARB_RSP_REG_EN to add a response register
// stage (read latency 2 instead of 1, same throughput).
module gs_mem_arb
    import gs_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32,
    parameter int BYTES     = 4,
    parameter int SRAM_AW   = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           req_valid,
    output logic [NUM_PORTS-1:0]           req_ready,
    input  logic [NUM_PORTS*BYTES-1:0]     req_we,
    input  logic [NUM_PORTS*ADDR_SIZE-1:0] req_addr,
    input  logic [NUM_PORTS*WORD_SIZE-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]           rsp_valid,
    output logic [WORD_SIZE-1:0]           rsp_rdata,
    output logic                           sram_cs,
    output logic                           sram_oe,
    output logic [BYTES-1:0]               sram_web,
    output logic [SRAM_AW-1:0]             sram_a,
    output logic [WORD_SIZE-1:0]           sram_di,
    input  logic [WORD_SIZE-1:0]           sram_do
);

    localparam int TW = gs_tag_width(NUM_PORTS);

    logic [NUM_PORTS-1:0] arb_req;
    logic [NUM_PORTS-1:0] grant;
    logic [TW-1:0]        grant_idx;
    logic                 grant_any;

    logic [BYTES-1:0]     sel_we;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0] sel_wdata;
    logic                 sel_is_read;

    logic                 tag_valid;
    logic [TW-1:0]        tag_port;
    logic                 rsp_live;
    logic [NUM_PORTS-1:0] rsp_hit;

    logic                 addr_unused;

    // Requests are masked while in reset so nothing is granted or accessed.
    assign arb_req = rst ? req_valid : '0;

    gs_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (TW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (arb_req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;

    assign sel_we      = req_we[int'(grant_idx)*BYTES +: BYTES];
    assign sel_addr    = req_addr[int'(grant_idx)*ADDR_SIZE +: ADDR_SIZE];
    assign sel_wdata   = req_wdata[int'(grant_idx)*WORD_SIZE +: WORD_SIZE];
    assign sel_is_read = (sel_we == BYTES'(GS_MEM_READ));

    // Byte-offset bits and bits above the bank are dropped on purpose, so
    // out-of-range addresses simply wrap within the bank.
    assign addr_unused = ^{sel_addr[1:0], sel_addr[ADDR_SIZE-1:SRAM_AW+2]};

    // The granted request drives the macro in the same cycle it is accepted.
    always_comb begin
        sram_cs  = 1'b0;
        sram_oe  = 1'b0;
        sram_web = '1;
        sram_a   = '0;
        sram_di  = '0;
        if (grant_any) begin
            sram_cs  = 1'b1;
            sram_oe  = sel_is_read;
            sram_web = ~sel_we;
            sram_a   = sel_addr[SRAM_AW+1:2];
            sram_di  = sel_wdata;
        end
    end

    // Only reads leave a tag behind; writes (full or partial) are silent.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_valid <= 1'b0;
            tag_port  <= '0;
        end else begin
            tag_valid <= grant_any && sel_is_read;
            tag_port  <= grant_idx;
        end
    end

    // A tag captured just before reset is dropped by gating with rst, so a
    // read cut off by reset never produces a response.
    assign rsp_live = tag_valid && rst;

    always_comb begin
        rsp_hit = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rsp_hit[i] = rsp_live && (int'(tag_port) == i);
        end
    end

`ifdef GS_MEM_ARB_RSP_REG_EN
    logic [NUM_PORTS-1:0] rsp_valid_q;
    logic [WORD_SIZE-1:0] rsp_rdata_q;

    // Extra response stage; the data register only loads on a live read so
    // it keeps presenting the last read word between responses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_hit;
            if (tag_valid) begin
                rsp_rdata_q <= sram_do;
            end
        end
    end

    assign rsp_valid = rsp_valid_q & {NUM_PORTS{rst}};
    assign rsp_rdata = rsp_rdata_q;
`else
    logic [WORD_SIZE-1:0] rdata_hold;

    // Shadow of the last delivered word so rsp_rdata holds between reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_hold <= '0;
        end else if (tag_valid) begin
            rdata_hold <= sram_do;
        end
    end

    assign rsp_valid = rsp_hit;
    assign rsp_rdata = rsp_live ? sram_do : rdata_hold;
`endif

endmodule

// File: tb/tb_gs_mem_arb.sv
// tb_gs_mem_arb
// Self-checking bench for gs_mem_arb with three ports and a behavioural
// SRAM macro. A reference model (word array, pointer integer, queue of due
// responses) predicts every cycle's outputs from the inputs.
module tb_gs_mem_arb;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int WS  = 32;
    localparam int B   = 4;
    localparam int SAW = 14;
    localparam int DEPTH = 1 << SAW;
`ifdef GS_MEM_ARB_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*B-1:0]    req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*WS-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [WS-1:0]     rsp_rdata;
    logic              sram_cs;
    logic              sram_oe;
    logic [B-1:0]      sram_web;
    logic [SAW-1:0]    sram_a;
    logic [WS-1:0]     sram_di;
    logic [WS-1:0]     sram_do;

    gs_mem_arb #(
        .NUM_PORTS (N),
        .ADDR_SIZE (AW),
        .WORD_SIZE (WS),
        .BYTES     (B),
        .SRAM_AW   (SAW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .sram_cs   (sram_cs),
        .sram_oe   (sram_oe),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_di   (sram_di),
        .sram_do   (sram_do)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port SRAM macro: read data appears after the edge.
    logic [WS-1:0] sram_mem [DEPTH];

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_oe) begin
                sram_do <= sram_mem[sram_a];
            end
            for (int b = 0; b < B; b++) begin
                if (!sram_web[b]) begin
                    sram_mem[sram_a][b*8 +: 8] <= sram_di[b*8 +: 8];
                end
            end
        end
    end

    // Reference model state
    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic [31:0] ref_mem [DEPTH];
    rsp_t        pend [$];
    int          ptr;
    logic [31:0] last_data;
    int          cyc;
    logic [N-1:0] last_grant;

    int vectors;
    int miscompares;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict and check outputs, advance model.
    task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [N*B-1:0] we,
                                 input logic [N*AW-1:0] a, input logic [N*WS-1:0] d);
        int          win;
        int          widx;
        logic [N-1:0] e_ready;
        logic        e_cs;
        logic        e_oe;
        logic [B-1:0] e_web;
        logic [SAW-1:0] e_a;
        logic [31:0] e_di;
        logic [N-1:0] e_rv;
        logic [31:0] e_rd;
        logic [B-1:0] w_we;
        logic [31:0] w_addr;
        logic [31:0] w_data;
        logic [31:0] word;

        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        #1;

        win = -1;
        widx = 0;
        e_ready = '0;
        e_cs = 1'b0;
        e_oe = 1'b0;
        e_web = '1;
        e_a = '0;
        e_di = '0;
        w_we = '0;
        w_addr = '0;
        w_data = '0;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                if (win < 0 && v[(ptr + i) % N]) win = (ptr + i) % N;
            end
        end
        if (win >= 0) begin
            w_we   = we[win*B +: B];
            w_addr = a[win*AW +: AW];
            w_data = d[win*WS +: WS];
            widx   = int'((w_addr >> 2) % DEPTH);
            e_ready[win] = 1'b1;
            e_cs  = 1'b1;
            e_oe  = (w_we == 0);
            e_web = ~w_we;
            e_a   = SAW'(widx);
            e_di  = w_data;
        end

        e_rv = '0;
        e_rd = last_data;
        if (r && pend.size() > 0 && pend[0].due == cyc) begin
            e_rv[pend[0].port] = 1'b1;
            e_rd = pend[0].data;
        end

        checkOutput("req_ready", 32'(req_ready), 32'(e_ready));
        checkOutput("sram_cs",   32'(sram_cs),   32'(e_cs));
        checkOutput("sram_oe",   32'(sram_oe),   32'(e_oe));
        checkOutput("sram_web",  32'(sram_web),  32'(e_web));
        checkOutput("sram_a",    32'(sram_a),    32'(e_a));
        checkOutput("sram_di",   sram_di,        e_di);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (r) checkOutput("rsp_rdata", rsp_rdata, e_rd);
        last_grant = e_ready;

        if (!r) begin
            pend.delete();
            ptr = 0;
            last_data = '0;
        end else begin
            if (e_rv != 0) begin
                last_data = e_rd;
                void'(pend.pop_front());
            end
            if (win >= 0) begin
                if (w_we == 0) begin
                    pend.push_back('{win, ref_mem[widx], cyc + LAT});
                end else begin
                    word = ref_mem[widx];
                    for (int bb = 0; bb < B; bb++) begin
                        if (w_we[bb]) word[bb*8 +: 8] = w_data[bb*8 +: 8];
                    end
                    ref_mem[widx] = word;
                end
                ptr = (win + 1) % N;
            end
        end
        cyc++;
    endtask

    initial begin
        logic [N-1:0]    cur_v;
        logic [N*B-1:0]  cur_we;
        logic [N*AW-1:0] cur_a;
        logic [N*WS-1:0] cur_d;
        logic            cur_r;
        logic [31:0]     tmp;
        int              rsp_cnt;

        vectors = 0;
        miscompares = 0;
        ptr = 0;
        last_data = '0;
        cyc = 0;
        last_grant = '0;
        sram_do = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        rst = 1'b0;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;

        $display("[TB] reset with all ports requesting");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, '1, '0, '0, '0);
            checkOutput("rst_ready_low", 32'(req_ready), 32'h0);
        end

        $display("[TB] contention: all ports reading from reset");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, '1, '0, {32'h8, 32'h4, 32'h0}, '0);
            checkOutput("contention_grant", 32'(req_ready), 32'(1 << (k % 3)));
        end
        for (int k = 0; k < LAT; k++) applyStimulus(1'b1, '0, '0, '0, '0);

        $display("[TB] single write then read on port 0");
        applyStimulus(1'b1, 3'b001, 12'h00F, 96'h10, 96'hDEADBEEF);
        applyStimulus(1'b1, 3'b001, 12'h000, 96'h10, 96'h0);
        for (int k = 0; k < LAT; k++) applyStimulus(1'b1, '0, '0, '0, '0);
        checkOutput("single_rd_valid", 32'(rsp_valid), 32'h1);
        checkOutput("single_rd_data", rsp_rdata, 32'hDEADBEEF);

        $display("[TB] byte-lane write then read");
        applyStimulus(1'b1, 3'b001, 12'h002, 96'h10, 96'h0000AB00);
        applyStimulus(1'b1, 3'b001, 12'h000, 96'h10, 96'h0);
        for (int k = 0; k < LAT; k++) applyStimulus(1'b1, '0, '0, '0, '0);
        checkOutput("byte_wr_data", rsp_rdata, 32'hDEADABEF);
        applyStimulus(1'b1, '0, '0, '0, '0);
        checkOutput("rdata_hold", rsp_rdata, 32'hDEADABEF);

        $display("[TB] reset cutting off an accepted read");
        applyStimulus(1'b1, 3'b010, '0, {32'h0, 32'h10, 32'h0}, '0);
        applyStimulus(1'b0, '0, '0, '0, '0);
        rsp_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, '0, '0, '0, '0);
            if (rsp_valid != 0) rsp_cnt++;
        end
        checkOutput("mid_rst_no_rsp", 32'(rsp_cnt), 32'h0);
        applyStimulus(1'b1, '1, '0, '0, '0);
        checkOutput("mid_rst_ptr0", 32'(req_ready), 32'h1);
        for (int k = 0; k < LAT + 1; k++) applyStimulus(1'b1, '0, '0, '0, '0);

        $display("[TB] back-to-back reads 0x0 and 0x4");
        applyStimulus(1'b1, 3'b001, '0, 96'h0, '0);
        applyStimulus(1'b1, 3'b001, '0, 96'h4, '0);
        for (int k = 0; k < LAT + 1; k++) applyStimulus(1'b1, '0, '0, '0, '0);

        $display("[TB] randomized traffic");
        cur_v = '0;
        cur_we = '0;
        cur_a = '0;
        cur_d = '0;
        for (int k = 0; k < 600; k++) begin
            cur_r = ($urandom_range(0, 59) != 0);
            for (int p = 0; p < N; p++) begin
                if (!(cur_v[p] && !last_grant[p])) begin
                    cur_v[p] = ($urandom_range(0, 3) != 0);
                    tmp = $urandom();
                    cur_a[p*AW +: AW] = (tmp & 32'hFFFF_0003) | (32'($urandom_range(0, 15)) << 2);
                    cur_we[p*B +: B] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                    cur_d[p*WS +: WS] = $urandom();
                end
            end
            applyStimulus(cur_r, cur_v, cur_we, cur_a, cur_d);
        end
        for (int k = 0; k < LAT + 1; k++) applyStimulus(1'b1, '0, '0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
